// File: rtl/fight_board.sv
// Game-state core for a two-player fighting game on a 4-cell track.
// Resolves both players' actions simultaneously each enabled clock edge.
module fight_board #(
  parameter logic [1:0] MAX_HLT   = 2'd3,
  parameter int         PUNCH_RNG = 0,
  parameter int         KICK_RNG  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw,
  input  logic [2:0] plr_1_act,
  input  logic [2:0] plr_2_act,
  output logic [1:0] plr_1_hlt,
  output logic [1:0] plr_2_hlt,
  output logic [1:0] plr_1_pos,
  output logic [1:0] plr_2_pos,
  output logic       plr_1_lst,
  output logic       plr_2_lst
);

  typedef enum logic [2:0] {
    ACT_NONE  = 3'b000,
    ACT_JUMP  = 3'b001,
    ACT_KICK  = 3'b010,
    ACT_PUNCH = 3'b011,
    ACT_GUARD = 3'b100,
    ACT_FWD   = 3'b101,
    ACT_BACK  = 3'b110,
    ACT_IDLE  = 3'b111
  } act_e;

  localparam logic [2:0] PUNCH_GAP = 3'(PUNCH_RNG);
  localparam logic [2:0] KICK_GAP  = 3'(KICK_RNG);

  logic [1:0] hlt_1_q, hlt_1_d, hlt_2_q, hlt_2_d;
  logic [1:0] pos_1_q, pos_1_d, pos_2_q, pos_2_d;
  logic [2:0] gap;
  logic       upd_en;
  logic       hit_on_1, hit_on_2;
  logic       fwd_clash;
  act_e       act_1, act_2;

  assign act_1 = act_e'(plr_1_act);
  assign act_2 = act_e'(plr_2_act);

  // Positions never overlap, so pos_1 + pos_2 <= 2 and the gap stays in 0..2.
  assign gap    = 3'd2 - ({1'b0, pos_1_q} + {1'b0, pos_2_q});
  assign upd_en = sw && (hlt_1_q != 2'd0) && (hlt_2_q != 2'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    hlt_1_d   = hlt_1_q;
    hlt_2_d   = hlt_2_q;
    pos_1_d   = pos_1_q;
    pos_2_d   = pos_2_q;
    hit_on_2  = ((act_1 == ACT_PUNCH) && (gap <= PUNCH_GAP) && (act_2 != ACT_GUARD)) ||
                ((act_1 == ACT_KICK)  && (gap <= KICK_GAP)  && (act_2 != ACT_JUMP));
    hit_on_1  = ((act_2 == ACT_PUNCH) && (gap <= PUNCH_GAP) && (act_1 != ACT_GUARD)) ||
                ((act_2 == ACT_KICK)  && (gap <= KICK_GAP)  && (act_1 != ACT_JUMP));
    fwd_clash = (act_1 == ACT_FWD) && (act_2 == ACT_FWD) && (gap == 3'd1);

    if (upd_en) begin
      if (hit_on_1 && (hlt_1_q != 2'd0)) hlt_1_d = hlt_1_q - 2'd1;
      if (hit_on_2 && (hlt_2_q != 2'd0)) hlt_2_d = hlt_2_q - 2'd1;

      // Hits above use pre-move positions; movement is resolved independently.
      if ((act_1 == ACT_FWD) && (gap >= 3'd1) && !fwd_clash) pos_1_d = pos_1_q + 2'd1;
      else if ((act_1 == ACT_BACK) && (pos_1_q != 2'd0))     pos_1_d = pos_1_q - 2'd1;

      if ((act_2 == ACT_FWD) && (gap >= 3'd1) && !fwd_clash) pos_2_d = pos_2_q + 2'd1;
      else if ((act_2 == ACT_BACK) && (pos_2_q != 2'd0))     pos_2_d = pos_2_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      hlt_1_q <= MAX_HLT;
      hlt_2_q <= MAX_HLT;
      pos_1_q <= 2'd0;
      pos_2_q <= 2'd0;
    end else begin
      hlt_1_q <= hlt_1_d;
      hlt_2_q <= hlt_2_d;
      pos_1_q <= pos_1_d;
      pos_2_q <= pos_2_d;
    end
  end

  assign plr_1_hlt = hlt_1_q;
  assign plr_2_hlt = hlt_2_q;
  assign plr_1_pos = pos_1_q;
  assign plr_2_pos = pos_2_q;
  assign plr_1_lst = (hlt_1_q == 2'd0);
  assign plr_2_lst = (hlt_2_q == 2'd0);

endmodule

// File: tb/tb_fight_board.sv
// Directed bench for fight_board: hand-computed health/position after each edge.
module tb_fight_board;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] JUMP  = 3'b001;
  localparam logic [2:0] KICK  = 3'b010;
  localparam logic [2:0] PUNCH = 3'b011;
  localparam logic [2:0] GUARD = 3'b100;
  localparam logic [2:0] FWD   = 3'b101;
  localparam logic [2:0] BACK  = 3'b110;
  localparam logic [2:0] IDLE  = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw  = 1'b0;
  logic [2:0] plr_1_act = NONE;
  logic [2:0] plr_2_act = NONE;
  logic [1:0] plr_1_hlt, plr_2_hlt, plr_1_pos, plr_2_pos;
  logic       plr_1_lst, plr_2_lst;

  int n_checks = 0;
  int n_fails  = 0;

  fight_board dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .plr_1_act (plr_1_act),
    .plr_2_act (plr_2_act),
    .plr_1_hlt (plr_1_hlt),
    .plr_2_hlt (plr_2_hlt),
    .plr_1_pos (plr_1_pos),
    .plr_2_pos (plr_2_pos),
    .plr_1_lst (plr_1_lst),
    .plr_2_lst (plr_2_lst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_val);
    n_checks++;
    if (obs != exp_val) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] a1, input logic [2:0] a2);
    rst       = r;
    sw        = s;
    plr_1_act = a1;
    plr_2_act = a2;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int h1, input int h2, input int p1, input int p2);
    check({tag, "/hlt1"}, int'(plr_1_hlt), h1);
    check({tag, "/hlt2"}, int'(plr_2_hlt), h2);
    check({tag, "/pos1"}, int'(plr_1_pos), p1);
    check({tag, "/pos2"}, int'(plr_2_pos), p2);
    check({tag, "/lst1"}, int'(plr_1_lst), (h1 == 0) ? 1 : 0);
    check({tag, "/lst2"}, int'(plr_2_lst), (h2 == 0) ? 1 : 0);
  endtask

  initial begin
    step(1'b0, 1'b1, FWD,   FWD);   chk_state("reset",          3, 3, 0, 0);
    step(1'b1, 1'b1, FWD,   FWD);   chk_state("fwd_gap2",       3, 3, 1, 1);
    step(1'b1, 1'b1, FWD,   FWD);   chk_state("fwd_gap0",       3, 3, 1, 1);
    step(1'b1, 1'b0, FWD,   FWD);   chk_state("sw_off_fwd",     3, 3, 1, 1);
    step(1'b1, 1'b0, PUNCH, PUNCH); chk_state("sw_off_punch",   3, 3, 1, 1);
    step(1'b1, 1'b1, NONE,  BACK);  chk_state("p2_back",        3, 3, 1, 0);
    step(1'b1, 1'b1, PUNCH, NONE);  chk_state("punch_gap1",     3, 3, 1, 0);
    step(1'b1, 1'b1, KICK,  IDLE);  chk_state("kick_gap1",      3, 2, 1, 0);
    step(1'b1, 1'b1, FWD,   FWD);   chk_state("fwd_clash",      3, 2, 1, 0);
    step(1'b1, 1'b1, NONE,  FWD);   chk_state("p2_fwd_gap1",    3, 2, 1, 1);
    step(1'b1, 1'b1, PUNCH, PUNCH); chk_state("mutual_punch",   2, 1, 1, 1);
    step(1'b1, 1'b1, FWD,   KICK);  chk_state("kick_p1_fwd",    1, 1, 1, 1);
    step(1'b1, 1'b1, PUNCH, GUARD); chk_state("punch_guarded",  1, 1, 1, 1);
    step(1'b1, 1'b1, KICK,  JUMP);  chk_state("kick_jumped",    1, 1, 1, 1);
    step(1'b1, 1'b1, GUARD, KICK);  chk_state("guard_vs_kick",  0, 1, 1, 1);
    step(1'b1, 1'b1, BACK,  PUNCH); chk_state("frozen_single",  0, 1, 1, 1);
    step(1'b0, 1'b1, BACK,  BACK);  chk_state("reset_after_ko", 3, 3, 0, 0);
    step(1'b1, 1'b1, BACK,  BACK);  chk_state("back_at_edge",   3, 3, 0, 0);
    step(1'b1, 1'b1, KICK,  PUNCH); chk_state("attack_gap2",    3, 3, 0, 0);
    step(1'b1, 1'b1, FWD,   NONE);  chk_state("p1_fwd",         3, 3, 1, 0);
    step(1'b1, 1'b1, FWD,   FWD);   chk_state("fwd_clash_2",    3, 3, 1, 0);
    step(1'b1, 1'b1, KICK,  NONE);  chk_state("kick_gap1_b",    3, 2, 1, 0);
    step(1'b0, 1'b1, KICK,  KICK);  chk_state("reset_mid",      3, 3, 0, 0);
    step(1'b1, 1'b1, FWD,   FWD);   chk_state("fwd_again",      3, 3, 1, 1);
    step(1'b1, 1'b1, PUNCH, BACK);  chk_state("hit_and_move",   3, 2, 1, 0);
    step(1'b1, 1'b1, FWD,   NONE);  chk_state("p1_fwd_adj",     3, 2, 2, 0);
    step(1'b1, 1'b1, PUNCH, PUNCH); chk_state("punch_2_0",      2, 1, 2, 0);
    step(1'b1, 1'b1, KICK,  KICK);  chk_state("mutual_kick",    1, 0, 2, 0);
    step(1'b1, 1'b1, PUNCH, PUNCH); chk_state("frozen_p2_ko",   1, 0, 2, 0);
    step(1'b0, 1'b1, NONE,  NONE);  chk_state("reset_3",        3, 3, 0, 0);
    step(1'b1, 1'b1, FWD,   FWD);   chk_state("fwd_3",          3, 3, 1, 1);
    step(1'b1, 1'b1, PUNCH, PUNCH); chk_state("draw_a",         2, 2, 1, 1);
    step(1'b1, 1'b1, PUNCH, PUNCH); chk_state("draw_b",         1, 1, 1, 1);
    step(1'b1, 1'b1, PUNCH, PUNCH); chk_state("draw",           0, 0, 1, 1);
    step(1'b1, 1'b1, BACK,  BACK);  chk_state("draw_frozen",    0, 0, 1, 1);
    step(1'b0, 1'b0, NONE,  NONE);  chk_state("reset_sw_off",   3, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
